// File: rtl/ram_pkg.sv
// Shared opcode fields, FSM state encoding and opcode decode for ram_ctrl_seq.
package ram_pkg;

  // Select nibble, opcode[15:12]
  localparam logic [3:0] RAM_OP = 4'h4;
  localparam logic [3:0] ROM_OP = 4'h3;
  localparam logic [3:0] REG_OP = 4'h9;
  localparam logic [3:0] PC_OP  = 4'h7;

  // Operation nibble, opcode[11:8]
  localparam logic [3:0] WRITE  = 4'h1;
  localparam logic [3:0] READ   = 4'h2;
  localparam logic [3:0] ADD    = 4'h3;
  localparam logic [3:0] CLEAR  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RMW,
    ST_WAIT_ROM,
    ST_CLEAR
  } state_t;

  // Decoded operation. REG_READ and PC_READ behave exactly like READ (mem[PA]).
  typedef enum logic [2:0] {
    DOP_ILLEGAL,
    DOP_WRITE_IMM,
    DOP_READ_PA,
    DOP_ADD_RMW,
    DOP_CLEAR,
    DOP_ROM_STORE,
    DOP_ROM_LINK,
    DOP_REG_WRITE
  } dop_t;

  function automatic dop_t decode_op(input logic [15:0] opcode);
    dop_t d;
    d = DOP_ILLEGAL;
    case (opcode[15:12])
      RAM_OP:
        case (opcode[11:8])
          WRITE:   d = DOP_WRITE_IMM;
          READ:    d = DOP_READ_PA;
          ADD:     d = DOP_ADD_RMW;
          CLEAR:   d = DOP_CLEAR;
          default: d = DOP_ILLEGAL;
        endcase
      ROM_OP:
        case (opcode[11:8])
          WRITE:   d = DOP_ROM_STORE;
          READ:    d = DOP_ROM_LINK;
          default: d = DOP_ILLEGAL;
        endcase
      REG_OP:
        case (opcode[11:8])
          WRITE:   d = DOP_REG_WRITE;
          READ:    d = DOP_READ_PA;
          default: d = DOP_ILLEGAL;
        endcase
      PC_OP:   d = DOP_READ_PA;
      default: d = DOP_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Single-port synchronous storage: one write or one read per cycle, registered read.
module ram_sp_array #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write has priority; rdata only changes on a read cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_ctrl_seq.sv
// Processor data RAM controller: opcode decode, FSM for RMW / ROM link / clear sweep.
module ram_ctrl_seq
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           opcode,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  req,
  input  logic                  rom_valid,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic [DATA_WIDTH-1:0] ram_rom_addr_link,
  output logic                  link_valid,
  output logic                  illegal_op
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ctr;
  logic [ADDR_WIDTH-1:0] dest;
  logic [DATA_WIDTH-1:0] addend;
  logic [DATA_WIDTH-1:0] read_hold;
  logic [DATA_WIDTH-1:0] link_hold;

  logic                  accept;
  dop_t                  dop;
  logic [ADDR_WIDTH-1:0] oa;
  logic [ADDR_WIDTH-1:0] pa;

  logic                  arr_we;
  logic                  arr_re;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_q;

  assign oa     = opcode[ADDR_WIDTH-1:0];
  assign pa     = operand[ADDR_WIDTH-1:0];
  assign dop    = decode_op(opcode);
  assign busy   = (state != ST_IDLE);
  assign accept = req && !busy;

  // The array read register already gives T+1 data, so the result is taken
  // from it in the valid cycle and held in a shadow register afterwards.
  assign read_data         = read_valid ? arr_q : read_hold;
  assign ram_rom_addr_link = link_valid ? arr_q : link_hold;

  ram_sp_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_q)
  );

  // Array port steering from the accepted opcode or the current FSM state
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = oa;
    arr_wdata = operand;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (dop)
            DOP_WRITE_IMM: begin arr_we = 1'b1; arr_addr = oa; arr_wdata = operand;    end
            DOP_ROM_STORE: begin arr_we = 1'b1; arr_addr = oa; arr_wdata = write_data; end
            DOP_REG_WRITE: begin arr_we = 1'b1; arr_addr = pa; arr_wdata = write_data; end
            DOP_READ_PA:   begin arr_re = 1'b1; arr_addr = pa; end
            DOP_ADD_RMW:   begin arr_re = 1'b1; arr_addr = oa; end
            DOP_ROM_LINK:  begin arr_re = 1'b1; arr_addr = oa; end
            default: ;
          endcase
        end
      end
      ST_RMW: begin
        arr_we    = 1'b1;
        arr_addr  = dest;
        arr_wdata = arr_q + addend;
      end
      ST_WAIT_ROM: begin
        arr_we    = rom_valid;
        arr_addr  = dest;
        arr_wdata = write_data;
      end
      ST_CLEAR: begin
        arr_we    = 1'b1;
        arr_addr  = ctr;
        arr_wdata = '0;
      end
      default: ;
    endcase
  end

  // Controller FSM with registered pulses and held results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ctr        <= '0;
      dest       <= '0;
      addend     <= '0;
      read_hold  <= '0;
      link_hold  <= '0;
      read_valid <= 1'b0;
      link_valid <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      link_valid <= 1'b0;
      illegal_op <= 1'b0;
      if (read_valid) read_hold <= arr_q;
      if (link_valid) link_hold <= arr_q;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (dop)
              DOP_READ_PA: read_valid <= 1'b1;
              DOP_ADD_RMW: begin
                read_valid <= 1'b1;
                dest       <= oa;
                addend     <= operand;
                state      <= ST_RMW;
              end
              DOP_ROM_LINK: begin
                link_valid <= 1'b1;
                dest       <= pa;
                state      <= ST_WAIT_ROM;
              end
              DOP_CLEAR: begin
                ctr   <= '0;
                state <= ST_CLEAR;
              end
              DOP_ILLEGAL: illegal_op <= 1'b1;
              default: ;
            endcase
          end
        end
        ST_RMW:      state <= ST_IDLE;
        ST_WAIT_ROM: if (rom_valid) state <= ST_IDLE;
        ST_CLEAR: begin
          ctr <= ctr + 1'b1;
          if (ctr == '1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
